id_hazard_stage: RTL and testbench
==================================

ID_HAZARD_STAGE -- requirements
Module: id_hazard_stage

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, meaning register and operand width.
REQ-002 The block SHALL have parameter NB_INST, default 32, meaning instruction and PC width.
REQ-003 The block SHALL have parameter NB_REG, default 5, meaning register address width; the register file holds 2**NB_REG entries.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset:
- i_clk  in  1  rising-edge clock
- i_reset  in  1  synchronous, active-high reset
REQ-005 The block SHALL have these remaining ports:
- i_enable  in  1  debug-unit step enable; low freezes the ID/EX register
- i_flush  in  1  insert bubble (branch taken upstream)
- i_pc  in  NB_INST  PC+4 of the instruction in IF/ID
- i_instruction  in  NB_INST  instruction in IF/ID
- i_wb_write  in  1  writeback enable
- i_wb_addr  in  NB_REG  writeback register
- i_wb_data  in  NB_DATA  writeback data
- i_address_read_debug  in  NB_REG  debug read address
- o_stall  out  1  load-use stall to PC and IF/ID
- o_data_read_debug  out  NB_DATA  debug read data
- o_pc  out  NB_INST  registered PC
- o_data_1, o_data_2  out  NB_DATA  registered rs and rt operands
- o_sign_extend  out  NB_DATA  registered extended immediate
- o_rs, o_rt, o_dest  out  NB_REG  registered source and destination registers
- o_opcode, o_funct  out  6  registered opcode and funct fields
- o_reg_write, o_mem_read, o_mem_write, o_valid  out  1  registered control signals

Function
REQ-006 Decode SHALL use these fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0]; register addresses use the low NB_REG bits of each field.
REQ-007 Register 0 SHALL read as 0 always, and writes to register 0 SHALL be ignored.
REQ-008 When i_wb_write=1 and i_wb_addr!=0, entry i_wb_addr SHALL take i_wb_data at the clock edge, independent of i_enable, o_stall and i_flush.
REQ-009 Reads SHALL be write-through: if a read address equals i_wb_addr (nonzero) while i_wb_write=1, the read SHALL return i_wb_data in that same cycle; this applies to the debug port too.
REQ-010 Immediate extension SHALL follow the opcode:
- 0x0C, 0x0D, 0x0E: zero-extend
- 0x0F: {imm, 16'b0}, zero-extended to NB_DATA
- all other opcodes: sign-extend
REQ-011 Control SHALL follow the opcode:
- reg_write=1 for opcode 0x00 with a nonzero instruction, 0x03, 0x08-0x0F and 0x20-0x25
- mem_read=1 for 0x20-0x25
- mem_write=1 for 0x28, 0x29, 0x2B
- all other opcodes: all three 0
REQ-012 dest SHALL be rd for opcode 0x00, 31 for 0x03, and rt otherwise.
REQ-013 uses_rt SHALL be 1 for opcodes 0x00, 0x04, 0x05, 0x28, 0x29, 0x2B.
REQ-014 o_stall SHALL be combinational: o_stall = i_enable & o_valid & o_mem_read & (o_dest!=0) & ((rs==o_dest) | (uses_rt & rt==o_dest)).
REQ-015 On each clock edge with i_enable=1, the ID/EX register SHALL load, in priority order:
- i_flush=1 or o_stall=1: a bubble (all ID/EX outputs 0)
- otherwise: the decoded instruction with o_valid=1
REQ-016 Latency SHALL be exactly one cycle from the IF/ID inputs to the ID/EX outputs.
REQ-017 A load-use stall SHALL last exactly one cycle, because the bubble clears the o_mem_read condition.
REQ-018 When i_enable=0, all ID/EX outputs SHALL hold their values and o_stall SHALL be 0.
REQ-019 The all-zero instruction SHALL decode as a NOP with all control signals 0.
REQ-020 o_data_read_debug SHALL be combinational from i_address_read_debug.

Reset
REQ-021 When i_reset=1 at a clock edge, all ID/EX outputs SHALL become 0 and all register entries SHALL become 0.
REQ-022 Reset SHALL take priority over i_enable, i_flush, o_stall and writeback.
REQ-023 Reset SHALL discard any in-flight stall, so o_stall=0 in the first cycle after reset.

Verification
REQ-024 Writeback: write r5=0x1234 while decoding 0x00A62020 (add r4,r5,r6) in the same cycle -> next cycle o_data_1=0x1234 (write-through), o_dest=4, o_reg_write=1.
REQ-025 Load-use: lw r8,0(r1) then add r9,r8,r2 -> o_stall=1 for exactly one cycle, one bubble with o_valid=0, then the add issues with o_rs=8.
REQ-026 Extension: ori imm 0xFFFF -> 0x0000FFFF; addi imm 0xFFFF -> 0xFFFFFFFF; lui imm 0x1234 -> 0x12340000.
REQ-027 Flush and freeze:
- i_flush during a stall -> bubble; the next cycle the add issues.
- i_enable=0 for 3 cycles -> ID/EX outputs unchanged and o_stall=0.
REQ-028 Register 0 and reset:
- write r0=0xFFFFFFFF -> debug read of r0 returns 0.
- reset mid-stall -> all outputs 0 and o_stall=0 next cycle.

Source files
------------

// File: rtl/id_hazard_stage.sv
// Instruction-decode stage: register file with write-through reads, immediate/control
// decode, load-use hazard detection and the ID/EX pipeline register.
module id_hazard_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_INST = 32,
    parameter int NB_REG  = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic [NB_INST-1:0] i_pc,
    input  logic [NB_INST-1:0] i_instruction,
    input  logic               i_wb_write,
    input  logic [NB_REG-1:0]  i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic [NB_REG-1:0]  i_address_read_debug,
    output logic               o_stall,
    output logic [NB_DATA-1:0] o_data_read_debug,
    output logic [NB_INST-1:0] o_pc,
    output logic [NB_DATA-1:0] o_data_1,
    output logic [NB_DATA-1:0] o_data_2,
    output logic [NB_DATA-1:0] o_sign_extend,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_dest,
    output logic [5:0]         o_opcode,
    output logic [5:0]         o_funct,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_valid
);

    localparam int NREGS = 2 ** NB_REG;

    logic [NB_DATA-1:0] r_regs [NREGS];

    logic [NB_INST-1:0] r_pc;
    logic [NB_DATA-1:0] r_data_1;
    logic [NB_DATA-1:0] r_data_2;
    logic [NB_DATA-1:0] r_sign_extend;
    logic [NB_REG-1:0]  r_rs;
    logic [NB_REG-1:0]  r_rt;
    logic [NB_REG-1:0]  r_dest;
    logic [5:0]         r_opcode;
    logic [5:0]         r_funct;
    logic               r_reg_write;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_valid;

    logic [5:0]         w_opcode;
    logic [5:0]         w_funct;
    logic [NB_REG-1:0]  w_rs;
    logic [NB_REG-1:0]  w_rt;
    logic [NB_REG-1:0]  w_rd;
    logic [15:0]        w_imm;
    logic [NB_DATA-1:0] w_data_1;
    logic [NB_DATA-1:0] w_data_2;
    logic [NB_DATA-1:0] w_debug;
    logic [NB_DATA-1:0] w_ext;
    logic [NB_REG-1:0]  w_dest;
    logic               w_reg_write;
    logic               w_mem_read;
    logic               w_mem_write;
    logic               w_uses_rt;
    logic               w_stall;
    logic               w_unused;

    assign w_opcode = i_instruction[31:26];
    assign w_funct  = i_instruction[5:0];
    assign w_rs     = i_instruction[21 +: NB_REG];
    assign w_rt     = i_instruction[16 +: NB_REG];
    assign w_rd     = i_instruction[11 +: NB_REG];
    assign w_imm    = i_instruction[15:0];
    assign w_unused = ^{i_instruction[10:6]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wb_write && (i_wb_addr != '0)) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    // Writeback in the same cycle bypasses the array so the decoder sees fresh data.
    always_comb begin
        w_data_1 = r_regs[w_rs];
        w_data_2 = r_regs[w_rt];
        w_debug  = r_regs[i_address_read_debug];
        if (i_wb_write && (i_wb_addr != '0)) begin
            if (w_rs == i_wb_addr)                 w_data_1 = i_wb_data;
            if (w_rt == i_wb_addr)                 w_data_2 = i_wb_data;
            if (i_address_read_debug == i_wb_addr) w_debug  = i_wb_data;
        end
        if (w_rs == '0)                 w_data_1 = '0;
        if (w_rt == '0)                 w_data_2 = '0;
        if (i_address_read_debug == '0) w_debug  = '0;
    end

    assign o_data_read_debug = w_debug;

    always_comb begin
        w_ext       = {{(NB_DATA-16){w_imm[15]}}, w_imm};
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_dest      = w_rt;
        w_uses_rt   = 1'b0;

        case (w_opcode)
            6'h0C, 6'h0D, 6'h0E: w_ext = {{(NB_DATA-16){1'b0}}, w_imm};
            6'h0F:               w_ext = {{(NB_DATA-32){1'b0}}, w_imm, 16'h0000};
            default:             ;
        endcase

        if (w_opcode == 6'h00) begin
            w_reg_write = (i_instruction != '0);
            w_dest      = w_rd;
        end else if (w_opcode == 6'h03) begin
            w_reg_write = 1'b1;
            w_dest      = NB_REG'(31);
        end else if ((w_opcode >= 6'h08) && (w_opcode <= 6'h0F)) begin
            w_reg_write = 1'b1;
        end else if ((w_opcode >= 6'h20) && (w_opcode <= 6'h25)) begin
            w_reg_write = 1'b1;
            w_mem_read  = 1'b1;
        end else if ((w_opcode == 6'h28) || (w_opcode == 6'h29) || (w_opcode == 6'h2B)) begin
            w_mem_write = 1'b1;
        end

        case (w_opcode)
            6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B: w_uses_rt = 1'b1;
            default:                                   w_uses_rt = 1'b0;
        endcase
    end

    // A load in EX whose target feeds this instruction forces one bubble.
    assign w_stall = i_enable & r_valid & r_mem_read & (r_dest != '0) &
                     ((w_rs == r_dest) | (w_uses_rt & (w_rt == r_dest)));
    assign o_stall = w_stall;

    always_ff @(posedge i_clk) begin
        if (i_reset || (i_enable && (i_flush || w_stall))) begin
            r_pc          <= '0;
            r_data_1      <= '0;
            r_data_2      <= '0;
            r_sign_extend <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_dest        <= '0;
            r_opcode      <= '0;
            r_funct       <= '0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_valid       <= 1'b0;
        end else if (i_enable) begin
            r_pc          <= i_pc;
            r_data_1      <= w_data_1;
            r_data_2      <= w_data_2;
            r_sign_extend <= w_ext;
            r_rs          <= w_rs;
            r_rt          <= w_rt;
            r_dest        <= w_dest;
            r_opcode      <= w_opcode;
            r_funct       <= w_funct;
            r_reg_write   <= w_reg_write;
            r_mem_read    <= w_mem_read;
            r_mem_write   <= w_mem_write;
            r_valid       <= 1'b1;
        end
    end

    assign o_pc          = r_pc;
    assign o_data_1      = r_data_1;
    assign o_data_2      = r_data_2;
    assign o_sign_extend = r_sign_extend;
    assign o_rs          = r_rs;
    assign o_rt          = r_rt;
    assign o_dest        = r_dest;
    assign o_opcode      = r_opcode;
    assign o_funct       = r_funct;
    assign o_reg_write   = r_reg_write;
    assign o_mem_read    = r_mem_read;
    assign o_mem_write   = r_mem_write;
    assign o_valid       = r_valid;

endmodule

// File: tb/tb_id_hazard_stage.sv
// Directed bench for id_hazard_stage: writeback bypass, load-use stall, extension,
// flush, freeze, register 0 and reset behaviour.
module tb_id_hazard_stage;

    localparam int NB_DATA = 32;
    localparam int NB_INST = 32;
    localparam int NB_REG  = 5;

    localparam logic [31:0] ADD_4_5_6 = 32'h00A62020;
    localparam logic [31:0] LW_8_1    = 32'h8C280000;
    localparam logic [31:0] ADD_9_8_2 = 32'h01024820;
    localparam logic [31:0] ORI_3     = 32'h3403FFFF;
    localparam logic [31:0] ADDI_3    = 32'h2003FFFF;
    localparam logic [31:0] LUI_3     = 32'h3C031234;
    localparam logic [31:0] SW_2_1    = 32'hAC220004;
    localparam logic [31:0] JAL       = 32'h0C000010;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic               i_enable;
    logic               i_flush;
    logic [NB_INST-1:0] i_pc;
    logic [NB_INST-1:0] i_instruction;
    logic               i_wb_write;
    logic [NB_REG-1:0]  i_wb_addr;
    logic [NB_DATA-1:0] i_wb_data;
    logic [NB_REG-1:0]  i_address_read_debug;
    logic               o_stall;
    logic [NB_DATA-1:0] o_data_read_debug;
    logic [NB_INST-1:0] o_pc;
    logic [NB_DATA-1:0] o_data_1;
    logic [NB_DATA-1:0] o_data_2;
    logic [NB_DATA-1:0] o_sign_extend;
    logic [NB_REG-1:0]  o_rs;
    logic [NB_REG-1:0]  o_rt;
    logic [NB_REG-1:0]  o_dest;
    logic [5:0]         o_opcode;
    logic [5:0]         o_funct;
    logic               o_reg_write;
    logic               o_mem_read;
    logic               o_mem_write;
    logic               o_valid;

    int total = 0;
    int bad   = 0;

    id_hazard_stage #(.NB_DATA(NB_DATA), .NB_INST(NB_INST), .NB_REG(NB_REG)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
        .i_pc(i_pc), .i_instruction(i_instruction),
        .i_wb_write(i_wb_write), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_address_read_debug(i_address_read_debug),
        .o_stall(o_stall), .o_data_read_debug(o_data_read_debug), .o_pc(o_pc),
        .o_data_1(o_data_1), .o_data_2(o_data_2), .o_sign_extend(o_sign_extend),
        .o_rs(o_rs), .o_rt(o_rt), .o_dest(o_dest), .o_opcode(o_opcode), .o_funct(o_funct),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_valid(o_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock and leave inputs free to change 1ns after the edge.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic setInstr(input logic [31:0] instr, input logic [31:0] pc);
        i_instruction = instr;
        i_pc          = pc;
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pc"},    o_pc, 32'h0);
        checkOutput({tag, "_d1"},    o_data_1, 32'h0);
        checkOutput({tag, "_d2"},    o_data_2, 32'h0);
        checkOutput({tag, "_ext"},   o_sign_extend, 32'h0);
        checkOutput({tag, "_regs"},  {17'h0, o_rs, o_rt, o_dest}, 32'h0);
        checkOutput({tag, "_opfn"},  {20'h0, o_opcode, o_funct}, 32'h0);
        checkOutput({tag, "_ctrl"},  {28'h0, o_reg_write, o_mem_read, o_mem_write, o_valid}, 32'h0);
        checkOutput({tag, "_stall"}, {31'h0, o_stall}, 32'h0);
    endtask

    initial begin
        i_reset = 1'b1; i_enable = 1'b1; i_flush = 1'b0;
        i_pc = '0; i_instruction = '0;
        i_wb_write = 1'b0; i_wb_addr = '0; i_wb_data = '0;
        i_address_read_debug = '0;
        applyStimulus(2);
        checkAllZero("reset");
        i_reset = 1'b0;

        // Writeback of r5 coinciding with decode of add r4,r5,r6
        i_wb_write = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'h1234;
        i_address_read_debug = 5'd5;
        setInstr(ADD_4_5_6, 32'h4);
        checkOutput("dbg_wt", o_data_read_debug, 32'h1234);
        applyStimulus(1);
        i_wb_write = 1'b0;
        #1;
        checkOutput("wb_d1",   o_data_1, 32'h1234);
        checkOutput("wb_d2",   o_data_2, 32'h0);
        checkOutput("wb_dest", {27'h0, o_dest}, 32'd4);
        checkOutput("wb_rsrt", {22'h0, o_rs, o_rt}, {22'h0, 5'd5, 5'd6});
        checkOutput("wb_ctrl", {28'h0, o_reg_write, o_mem_read, o_mem_write, o_valid}, 32'b1001);
        checkOutput("wb_pc",   o_pc, 32'h4);
        checkOutput("wb_fn",   {20'h0, o_opcode, o_funct}, {20'h0, 6'h00, 6'h20});
        checkOutput("dbg_r5",  o_data_read_debug, 32'h1234);

        // Load-use: lw r8 then add r9,r8,r2
        setInstr(LW_8_1, 32'h8);
        applyStimulus(1);
        checkOutput("lw_ctrl", {28'h0, o_reg_write, o_mem_read, o_mem_write, o_valid}, 32'b1101);
        checkOutput("lw_dest", {27'h0, o_dest}, 32'd8);
        setInstr(ADD_9_8_2, 32'hC);
        checkOutput("lu_stall1", {31'h0, o_stall}, 32'h1);
        applyStimulus(1);
        checkOutput("lu_bub_valid", {31'h0, o_valid}, 32'h0);
        checkOutput("lu_bub_mr",    {31'h0, o_mem_read}, 32'h0);
        checkOutput("lu_stall0",    {31'h0, o_stall}, 32'h0);
        applyStimulus(1);
        checkOutput("lu_add_valid", {31'h0, o_valid}, 32'h1);
        checkOutput("lu_add_rs",    {27'h0, o_rs}, 32'd8);
        checkOutput("lu_add_dest",  {27'h0, o_dest}, 32'd9);
        checkOutput("lu_add_stall", {31'h0, o_stall}, 32'h0);

        // Immediate extension
        setInstr(ORI_3, 32'h10);
        applyStimulus(1);
        checkOutput("ori_ext",  o_sign_extend, 32'h0000FFFF);
        checkOutput("ori_ctrl", {28'h0, o_reg_write, o_mem_read, o_mem_write, o_valid}, 32'b1001);
        checkOutput("ori_dest", {27'h0, o_dest}, 32'd3);
        setInstr(ADDI_3, 32'h14);
        applyStimulus(1);
        checkOutput("addi_ext", o_sign_extend, 32'hFFFFFFFF);
        setInstr(LUI_3, 32'h18);
        applyStimulus(1);
        checkOutput("lui_ext",  o_sign_extend, 32'h12340000);
        setInstr(SW_2_1, 32'h1C);
        applyStimulus(1);
        checkOutput("sw_ctrl",  {28'h0, o_reg_write, o_mem_read, o_mem_write, o_valid}, 32'b0011);
        checkOutput("sw_ext",   o_sign_extend, 32'h4);
        setInstr(JAL, 32'h20);
        applyStimulus(1);
        checkOutput("jal_dest", {27'h0, o_dest}, 32'd31);
        checkOutput("jal_rw",   {31'h0, o_reg_write}, 32'h1);

        // Flush while a stall is pending
        setInstr(LW_8_1, 32'h24);
        applyStimulus(1);
        setInstr(ADD_9_8_2, 32'h28);
        i_flush = 1'b1;
        #1;
        checkOutput("fl_stall", {31'h0, o_stall}, 32'h1);
        applyStimulus(1);
        i_flush = 1'b0;
        #1;
        checkOutput("fl_bub", {31'h0, o_valid}, 32'h0);
        applyStimulus(1);
        checkOutput("fl_add_valid", {31'h0, o_valid}, 32'h1);
        checkOutput("fl_add_rs",    {27'h0, o_rs}, 32'd8);

        // Freeze with a load in EX and a dependent instruction waiting
        setInstr(LW_8_1, 32'h2C);
        applyStimulus(1);
        setInstr(ADD_9_8_2, 32'h30);
        i_enable = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checkOutput("frz_stall", {31'h0, o_stall}, 32'h0);
            applyStimulus(1);
            checkOutput("frz_pc",   o_pc, 32'h2C);
            checkOutput("frz_ctrl", {28'h0, o_reg_write, o_mem_read, o_mem_write, o_valid}, 32'b1101);
            checkOutput("frz_dest", {27'h0, o_dest}, 32'd8);
        end
        i_enable = 1'b1;
        #1;
        checkOutput("frz_resume_stall", {31'h0, o_stall}, 32'h1);
        applyStimulus(1);
        checkOutput("frz_resume_bub", {31'h0, o_valid}, 32'h0);

        // Register 0 is hard-wired to zero
        i_wb_write = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'hFFFFFFFF;
        i_address_read_debug = 5'd0;
        #1;
        checkOutput("r0_wt", o_data_read_debug, 32'h0);
        applyStimulus(1);
        i_wb_write = 1'b0;
        #1;
        checkOutput("r0_rd", o_data_read_debug, 32'h0);

        // All-zero instruction is a NOP
        setInstr(32'h0, 32'h34);
        applyStimulus(1);
        checkOutput("nop_ctrl", {29'h0, o_reg_write, o_mem_read, o_mem_write}, 32'h0);
        checkOutput("nop_dest", {27'h0, o_dest}, 32'd0);

        // Reset in the middle of a load-use stall
        setInstr(LW_8_1, 32'h38);
        applyStimulus(1);
        setInstr(ADD_9_8_2, 32'h3C);
        checkOutput("rs_stall_pre", {31'h0, o_stall}, 32'h1);
        i_reset = 1'b1;
        i_wb_write = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'h77;
        applyStimulus(1);
        i_wb_write = 1'b0;
        #1;
        checkAllZero("rst_mid");
        i_reset = 1'b0;
        i_address_read_debug = 5'd5;
        #1;
        checkOutput("rst_r5", o_data_read_debug, 32'h0);
        i_address_read_debug = 5'd7;
        #1;
        checkOutput("rst_r7", o_data_read_debug, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
